pipeline_feeder: RTL and testbench

//  Transmit side of the bot/result interface of fullPipeline. Pulls bots from an upstream

---
 rtl/pipeline_feeder.sv | 151 +++++++++++++++
 tb/tb_pipeline_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_feeder.sv
// pipeline_feeder: streams upstream bots into fullPipeline with round-robin slot indices,
// tags each slot readout with the sequence number it completes, then drains and flushes.
module pipeline_feeder #(
    parameter int ADDR_WIDTH     = 2,
    parameter int FULL_THRESHOLD = 20,
    parameter int READ_LATENCY   = 3,
    parameter int DRAIN_CYCLES   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           botCount,
    input  logic [127:0]          botIn,
    input  logic [5:0]            botInPermutations,
    input  logic                  botInValid,
    output logic                  botInReady,
    output logic [127:0]          bot,
    output logic [ADDR_WIDTH-1:0] botIndex,
    output logic                  isBotValid,
    output logic [5:0]            validBotPermutations,
    input  logic [4:0]            fifoFullness,
    input  logic [37:0]           summedDataIn,
    input  logic [2:0]            pcoeffCountIn,
    output logic                  resultValid,
    output logic [31:0]           resultSeq,
    output logic [37:0]           resultSum,
    output logic [2:0]            resultPcoeffCount,
    output logic                  busy,
    output logic                  done
);

    localparam int SLOTS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FLUSH_LAST = (ADDR_WIDTH + 1)'(SLOTS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STREAM  = 3'd1,
        DRAIN   = 3'd2,
        FLUSH   = 3'd3,
        WAIT_RD = 3'd4
    } state_t;

    state_t                state;
    state_t                nextState;
    logic [31:0]           seq;
    logic [31:0]           botCountReg;
    logic [15:0]           drainCnt;
    logic [ADDR_WIDTH:0]   flushCnt;
    logic [7:0]            waitCnt;
    logic                  fire;
    logic                  issue;
    logic                  tagHit;

    logic                  tagValid [0:READ_LATENCY];
    logic [31:0]           tagSeq   [0:READ_LATENCY];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = STREAM;
            STREAM:  if (seq == botCountReg) nextState = DRAIN;
            DRAIN:   if (fifoFullness == 5'd0 && drainCnt == 16'(DRAIN_CYCLES - 1)) nextState = FLUSH;
            FLUSH:   if (flushCnt == FLUSH_LAST) nextState = WAIT_RD;
            WAIT_RD: if (waitCnt == 8'(READ_LATENCY)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        botInReady = (state == STREAM) && (seq < botCountReg)
                     && (32'(fifoFullness) < FULL_THRESHOLD);
        fire       = botInValid && botInReady;
        issue      = (state == FLUSH) || ((state == STREAM) && fire);
        busy       = (state != IDLE);
        // A read of slot n mod SLOTS completes bot n-SLOTS, if that bot belongs to this run.
        tagHit     = (seq >= 32'(SLOTS)) && ((seq - 32'(SLOTS)) < botCountReg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq         <= '0;
            botCountReg <= '0;
            drainCnt    <= '0;
            flushCnt    <= '0;
            waitCnt     <= '0;
            done        <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                seq         <= '0;
                botCountReg <= botCount;
            end else if (issue) begin
                seq <= seq + 32'd1;
            end
            drainCnt <= (state == DRAIN && fifoFullness == 5'd0) ? drainCnt + 16'd1 : '0;
            flushCnt <= (state == FLUSH) ? flushCnt + 1'b1 : '0;
            waitCnt  <= (state == WAIT_RD) ? waitCnt + 8'd1 : '0;
            done     <= (state == WAIT_RD) && (waitCnt == 8'(READ_LATENCY));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bot                  <= '0;
            botIndex             <= '0;
            isBotValid           <= 1'b0;
            validBotPermutations <= '0;
        end else begin
            isBotValid           <= issue;
            validBotPermutations <= (state == STREAM && fire) ? botInPermutations : 6'd0;
            if (issue) botIndex <= seq[ADDR_WIDTH-1:0];
            if (state == STREAM && fire) bot <= botIn;
        end
    end

    // NOTE: the tag delay line is reset, not just its valid bits' consumers, so a run
    // aborted by rst can never surface a stale tag as a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tagValid[k] <= 1'b0;
                tagSeq[k]   <= '0;
            end
            resultValid       <= 1'b0;
            resultSeq         <= '0;
            resultSum         <= '0;
            resultPcoeffCount <= '0;
        end else begin
            tagValid[0] <= issue && tagHit;
            tagSeq[0]   <= seq - 32'(SLOTS);
            for (int k = 1; k <= READ_LATENCY; k++) begin
                tagValid[k] <= tagValid[k-1];
                tagSeq[k]   <= tagSeq[k-1];
            end
            resultValid <= tagValid[READ_LATENCY];
            if (tagValid[READ_LATENCY]) begin
                resultSeq         <= tagSeq[READ_LATENCY];
                resultSum         <= summedDataIn;
                resultPcoeffCount <= pcoeffCountIn;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_feeder.sv
// tb_pipeline_feeder: directed runs of pipeline_feeder against a behavioural slot-sum pipeline,
// checking issue order, result tagging, throttling, restart and mid-run reset.
module tb_pipeline_feeder;

    localparam int AW    = 2;
    localparam int SLOTS = 4;
    localparam int RL    = 2;
    localparam int FT    = 20;
    localparam int DC    = 4;

    localparam int M_NORM   = 0;
    localparam int M_STALL  = 1;
    localparam int M_TOGGLE = 2;
    localparam int M_RST    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   botCount = '0;
    logic [127:0]  botIn = '0;
    logic [5:0]    botInPermutations = '0;
    logic          botInValid = 1'b0;
    logic          botInReady;
    logic [127:0]  bot;
    logic [AW-1:0] botIndex;
    logic          isBotValid;
    logic [5:0]    validBotPermutations;
    logic [4:0]    fifoFullness = '0;
    logic [37:0]   summedDataIn;
    logic [2:0]    pcoeffCountIn;
    logic          resultValid;
    logic [31:0]   resultSeq;
    logic [37:0]   resultSum;
    logic [2:0]    resultPcoeffCount;
    logic          busy;
    logic          done;

    pipeline_feeder #(
        .ADDR_WIDTH(AW), .FULL_THRESHOLD(FT), .READ_LATENCY(RL), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .botCount(botCount),
        .botIn(botIn), .botInPermutations(botInPermutations), .botInValid(botInValid),
        .botInReady(botInReady), .bot(bot), .botIndex(botIndex), .isBotValid(isBotValid),
        .validBotPermutations(validBotPermutations), .fifoFullness(fifoFullness),
        .summedDataIn(summedDataIn), .pcoeffCountIn(pcoeffCountIn),
        .resultValid(resultValid), .resultSeq(resultSeq), .resultSum(resultSum),
        .resultPcoeffCount(resultPcoeffCount), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] srcBot(input int k);
        return {32'hB0B0_0000 + 32'(k), 32'h1234_5678, 32'h0000_0003 ^ 32'(k),
                32'hC000_0000 + 32'h111 * 32'(k)};
    endfunction

    function automatic logic [5:0] srcPerm(input int k);
        return 6'(k % 7);
    endfunction

    function automatic logic [37:0] expSum(input int k);
        logic [127:0] b;
        b = srcBot(k);
        return (srcPerm(k) == 6'd0) ? 38'd0 : b[37:0] + 38'(srcPerm(k));
    endfunction

    function automatic logic [2:0] expPc(input int k);
        return 3'($countones(srcPerm(k)));
    endfunction

    typedef struct {
        logic [AW-1:0] idx;
        logic [5:0]    perms;
        logic [127:0]  bot;
        int            cyc;
    } issue_t;

    typedef struct {
        logic [31:0] seq;
        logic [37:0] sum;
        logic [2:0]  pc;
        int          cyc;
    } res_t;

    issue_t      issQ[$];
    res_t        resQ[$];
    int          doneCount = 0;
    int          doneCyc = 0;
    int          dropCyc = -1;
    logic [37:0] slotSum [SLOTS] = '{default: '0};
    logic [2:0]  slotPc  [SLOTS] = '{default: '0};
    logic [40:0] pipeM   [1:RL+1];

    // Pipeline model: a read of a slot returns its previous contents RL cycles later,
    // then the issued bot replaces them (mask 0 leaves a 0/0 result).
    always @(negedge clk) begin
        logic [40:0] rd;
        rd = {3'h5, 38'h2A_DEAD_BEEF};
        if (isBotValid === 1'b1) begin
            issQ.push_back('{idx: botIndex, perms: validBotPermutations, bot: bot, cyc: cyc});
            rd = {slotPc[botIndex], slotSum[botIndex]};
            if (validBotPermutations == 6'd0) begin
                slotSum[botIndex] = '0;
                slotPc[botIndex]  = '0;
            end else begin
                slotSum[botIndex] = bot[37:0] + 38'(validBotPermutations);
                slotPc[botIndex]  = 3'($countones(validBotPermutations));
            end
        end
        for (int k = RL + 1; k >= 2; k--) pipeM[k] = pipeM[k-1];
        pipeM[1] = rd;
        {pcoeffCountIn, summedDataIn} = pipeM[RL+1];
        if (resultValid === 1'b1)
            resQ.push_back('{seq: resultSeq, sum: resultSum, pc: resultPcoeffCount, cyc: cyc});
        if (done === 1'b1) begin
            doneCount++;
            doneCyc = cyc;
        end
    end

    task automatic runBots(input int n, input int mode);
        int srcIdx   = 0;
        int stallCnt = 0;
        int rstPhase = 0;
        bit finished = 1'b0;
        issQ.delete();
        resQ.delete();
        doneCount = 0;
        dropCyc   = -1;
        @(negedge clk);
        start    = 1'b1;
        botCount = 32'(n);
        for (int c = 0; c < 2000 && !finished; c++) begin
            @(negedge clk);
            start             = (mode == M_TOGGLE && c == 4);
            if (mode == M_TOGGLE && c == 4) botCount = 32'd99;
            botInValid        = (mode == M_TOGGLE) ? (c % 2 == 0) : 1'b1;
            botIn             = srcBot(srcIdx);
            botInPermutations = srcPerm(srcIdx);
            fifoFullness      = 5'd0;
            if (mode == M_STALL && srcIdx == 3 && stallCnt < 5) begin
                fifoFullness = 5'(FT);
                stallCnt++;
            end else if (mode == M_STALL && stallCnt == 5 && dropCyc < 0) begin
                dropCyc = cyc;
            end
            rst = (rstPhase == 1);
            #1;
            if (c == 0) check("busy after start", 128'(busy), 128'(1));
            if (fifoFullness != 5'd0) begin
                check("stall ready", 128'(botInReady), 128'(0));
                if (stallCnt >= 2) begin
                    check("stall isBotValid", 128'(isBotValid), 128'(0));
                    check("stall botIndex held", 128'(botIndex), 128'(2));
                end
            end
            if (rstPhase == 2) begin
                check("rst bot", bot, 128'(0));
                check("rst outputs", 128'({botInReady, botIndex, isBotValid, validBotPermutations,
                      resultValid, resultSeq, resultSum, resultPcoeffCount, busy, done}), 128'(0));
                finished = 1'b1;
            end else if (rstPhase == 1) begin
                rstPhase = 2;
            end else if (mode == M_RST && issQ.size() == n + 1) begin
                rstPhase = 1;
            end
            if (botInValid && botInReady) srcIdx++;
            if (doneCount > 0) finished = 1'b1;
        end
        check("run terminates", 128'(finished), 128'(1));
        botInValid = 1'b0;
    endtask

    task automatic verifyRun(input int n);
        check("issue count", 128'(issQ.size()), 128'(n + SLOTS));
        for (int i = 0; i < issQ.size(); i++) begin
            check("issue idx", 128'(issQ[i].idx), 128'(i % SLOTS));
            check("issue perms", 128'(issQ[i].perms), (i < n) ? 128'(srcPerm(i)) : 128'(0));
            if (i < n) check("issue bot", issQ[i].bot, srcBot(i));
        end
        check("result count", 128'(resQ.size()), 128'(n));
        for (int i = 0; i < resQ.size(); i++) begin
            check("result seq", 128'(resQ[i].seq), 128'(i));
            check("result sum", 128'(resQ[i].sum), 128'(expSum(i)));
            check("result pcoeff", 128'(resQ[i].pc), 128'(expPc(i)));
        end
        check("done pulses", 128'(doneCount), 128'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset bot", bot, 128'(0));
        check("reset outputs", 128'({botInReady, botIndex, isBotValid, validBotPermutations,
              resultValid, resultSeq, resultSum, resultPcoeffCount, busy, done}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic run: three bots, results only surface on the flush reads.
        runBots(3, M_NORM);
        verifyRun(3);
        check("busy low at done", 128'(busy), 128'(0));
        if (issQ.size() == 7 && resQ.size() == 3) begin
            check("done latency", 128'(doneCyc - issQ[6].cyc), 128'(3));
            check("result0 latency", 128'(resQ[0].cyc - issQ[4].cyc), 128'(3));
            check("seq1 sum", 128'(resQ[1].sum), 128'(38'h02_C000_0112));
            check("seq2 sum", 128'(resQ[2].sum), 128'(38'h01_C000_0224));
            check("seq0 sum", 128'({resQ[0].pc, resQ[0].sum}), 128'(0));
        end

        // Slot reuse: results 0..5 come out while still streaming.
        runBots(10, M_NORM);
        verifyRun(10);
        if (issQ.size() == 14 && resQ.size() == 10)
            check("mid-stream results", 128'(resQ[5].cyc < issQ[10].cyc), 128'(1));

        // Fullness stall for five cycles after the third bot.
        runBots(8, M_STALL);
        verifyRun(8);
        if (issQ.size() > 3)
            check("resume after stall", 128'(issQ[3].cyc - dropCyc), 128'(1));

        // Empty run: flush reads only.
        runBots(0, M_NORM);
        verifyRun(0);

        // Bubbly upstream and a stray start mid-stream.
        runBots(6, M_TOGGLE);
        verifyRun(6);
        if (issQ.size() > 2) begin
            check("bubble spacing 0-1", 128'(issQ[1].cyc - issQ[0].cyc), 128'(2));
            check("bubble spacing 1-2", 128'(issQ[2].cyc - issQ[1].cyc), 128'(2));
        end

        // Reset during FLUSH, then a clean rerun.
        runBots(5, M_RST);
        begin
            int r0;
            r0 = resQ.size();
            repeat (10) @(negedge clk);
            #1;
            check("no results after rst", 128'(resQ.size()), 128'(r0));
            check("no done after rst", 128'(doneCount), 128'(0));
            check("idle after rst", 128'(busy), 128'(0));
        end
        runBots(3, M_NORM);
        verifyRun(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
